// File: rtl/acude_controller.sv
// acude_controller: reservoir level display and fill-pump controller.
// Debounces the 2-bit level sensor, runs a fill/hold/fault state machine that
// drives the pump, and decodes the level, pump and fault onto a 7-segment
// display and a state code.
// Optional build macro ACUDE_BLINK_EN: blinks the fault code with a half-period
// of BLINK_HALF cycles. Without it the fault code is steady.
module acude_controller #(
    parameter int STABLE_CYCLES = 4,
    parameter int FILL_TIMEOUT  = 16,
    parameter int BLINK_HALF    = 8
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic [1:0] nivel,
    input  logic       reconhece,
    output logic [7:0] seg,
    output logic       bomba,
    output logic       alarme,
    output logic [1:0] estado
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(FILL_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ARM   = CW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] TIMER_MAX = TW'(FILL_TIMEOUT - 1);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 2");
    end
    if (FILL_TIMEOUT < 2) begin : g_bad_timeout
        $error("FILL_TIMEOUT must be at least 2");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("BLINK_HALF must be at least 1");
    end

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        ENCHENDO = 2'b01,
        CHEIO    = 2'b10,
        FALHA    = 2'b11
    } state_t;

    logic [1:0]    r_nivel_s;
    logic [1:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_nivel_ok;
    logic [1:0]    r_nivel_prev;
    logic [TW-1:0] r_timer;
    state_t        r_state;
    state_t        w_state_next;
    logic          w_rise;
    logic          w_blank;

    // Sync stage plus debounce: a new level is accepted after it has been seen
    // unchanged for STABLE_CYCLES consecutive samples; the accept fires on the
    // same edge the counter reaches its saturation value.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_nivel_s    <= '0;
            r_cand       <= '0;
            r_cnt        <= '0;
            r_nivel_ok   <= '0;
            r_nivel_prev <= '0;
        end else begin
            r_nivel_s    <= nivel;
            r_nivel_prev <= r_nivel_ok;
            if (r_nivel_s != r_cand) begin
                r_cand <= r_nivel_s;
                r_cnt  <= '0;
            end else begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (r_cnt >= CNT_ARM) begin
                    r_nivel_ok <= r_cand;
                end
            end
        end
    end

    assign w_rise = (r_nivel_ok > r_nivel_prev);

    // Fill timer: cleared outside ENCHENDO (so it is zero on entry) and on every
    // observed level rise; a level drop keeps it counting.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state != ENCHENDO || w_rise) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state <= PARADO;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; full level is tested before the timeout so it wins a tie.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            PARADO: begin
                if (r_nivel_ok == 2'b11) begin
                    w_state_next = CHEIO;
                end else if (r_nivel_ok == 2'b00) begin
                    w_state_next = ENCHENDO;
                end
            end
            ENCHENDO: begin
                if (r_nivel_ok == 2'b11) begin
                    w_state_next = CHEIO;
                end else if (r_timer == TIMER_MAX) begin
                    w_state_next = FALHA;
                end
            end
            CHEIO: begin
                if (r_nivel_ok != 2'b11) begin
                    w_state_next = PARADO;
                end
            end
            FALHA: begin
                if (reconhece) begin
                    w_state_next = PARADO;
                end
            end
            default: w_state_next = PARADO;
        endcase
    end

`ifdef ACUDE_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_off;

    // Fault blink: restarts in the visible phase on every entry to FALHA.
    always_ff @(posedge clk_2) begin
        if (reset || r_state != FALHA) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blank = r_blink_off;
`else
    assign w_blank = 1'b0;
`endif

    // Moore output decode from the state and accepted level registers.
    always_comb begin
        bomba  = (r_state == ENCHENDO);
        alarme = (r_state == FALHA);
        estado = r_state;
        seg    = 8'h00;
        if (r_state == FALHA) begin
            seg = w_blank ? 8'h00 : 8'h71;
        end else begin
            unique case (r_nivel_ok)
                2'b00:   seg[6:0] = 7'h3F;
                2'b01:   seg[6:0] = 7'h06;
                2'b10:   seg[6:0] = 7'h5B;
                default: seg[6:0] = 7'h4F;
            endcase
            seg[7] = (r_state == ENCHENDO);
        end
    end

endmodule

// File: tb/tb_acude_controller.sv
// tb_acude_controller: directed, self-checking bench for acude_controller
// with default parameters.
module tb_acude_controller;

    logic       clk_2     = 1'b0;
    logic       reset     = 1'b1;
    logic [1:0] nivel     = 2'b00;
    logic       reconhece = 1'b0;
    logic [7:0] seg;
    logic       bomba;
    logic       alarme;
    logic [1:0] estado;

    int n_checks = 0;
    int n_errors = 0;

    acude_controller #(
        .STABLE_CYCLES(4),
        .FILL_TIMEOUT (16),
        .BLINK_HALF   (8)
    ) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .nivel    (nivel),
        .reconhece(reconhece),
        .seg      (seg),
        .bomba    (bomba),
        .alarme   (alarme),
        .estado   (estado)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    task automatic outs(input string tag, input logic [7:0] s, input logic b,
                        input logic a, input logic [1:0] e);
        check({tag, ".seg"},    seg,              s);
        check({tag, ".bomba"},  {7'b0, bomba},    {7'b0, b});
        check({tag, ".alarme"}, {7'b0, alarme},   {7'b0, a});
        check({tag, ".estado"}, {6'b0, estado},   {6'b0, e});
    endtask

    logic [7:0] fault_hold_seg;

    initial begin
`ifdef ACUDE_BLINK_EN
        fault_hold_seg = 8'h00;
`else
        fault_hold_seg = 8'h71;
`endif
        // Reset and first fill
        reset = 1'b1;
        nivel = 2'b00;
        tick(2);
        outs("rst", 8'h3F, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        tick(1);
        outs("fill_start", 8'hBF, 1'b1, 1'b0, 2'd1);

        // Fill steps: accepted level appears 5 edges after presentation
        nivel = 2'b01;
        tick(4);
        check("lvl01_pre", seg, 8'hBF);
        tick(1);
        outs("lvl01", 8'h86, 1'b1, 1'b0, 2'd1);
        tick(1);
        nivel = 2'b10;
        tick(4);
        check("lvl10_pre", seg, 8'h86);
        tick(1);
        outs("lvl10", 8'hDB, 1'b1, 1'b0, 2'd1);
        tick(1);
        nivel = 2'b11;
        tick(4);
        check("lvl11_pre", seg, 8'hDB);
        tick(1);
        outs("lvl11", 8'hCF, 1'b1, 1'b0, 2'd1);
        tick(1);
        outs("cheio", 8'h4F, 1'b0, 1'b0, 2'd2);

        // Drop from full: hysteresis back to PARADO, pump stays off
        nivel = 2'b10;
        tick(5);
        outs("cheio_drop", 8'h5B, 1'b0, 1'b0, 2'd2);
        tick(1);
        outs("parado", 8'h5B, 1'b0, 1'b0, 2'd0);

        // Debounce: a 3-cycle glitch to 00 never reaches the accepted level
        for (int i = 0; i < 11; i++) begin
            if (i == 0) nivel = 2'b00;
            if (i == 3) nivel = 2'b10;
            tick(1);
            check("glitch.seg", seg, 8'h5B);
            check("glitch.estado", {6'b0, estado}, 8'h00);
        end

        // Timeout fault
        nivel = 2'b00;
        tick(5);
        outs("drain", 8'h3F, 1'b0, 1'b0, 2'd0);
        tick(1);
        outs("refill", 8'hBF, 1'b1, 1'b0, 2'd1);
        tick(15);
        outs("pre_fault", 8'hBF, 1'b1, 1'b0, 2'd1);
        tick(1);
        outs("fault", 8'h71, 1'b0, 1'b1, 2'd3);
        tick(10);
        outs("fault_hold", fault_hold_seg, 1'b0, 1'b1, 2'd3);
        reconhece = 1'b1;
        tick(1);
        outs("ack", 8'h3F, 1'b0, 1'b0, 2'd0);
        reconhece = 1'b0;
        tick(1);
        outs("ack_refill", 8'hBF, 1'b1, 1'b0, 2'd1);

        // Full arrives on the same cycle the timer reaches its last value
        tick(10);
        nivel = 2'b11;
        tick(5);
        outs("prio_pre", 8'hCF, 1'b1, 1'b0, 2'd1);
        tick(1);
        outs("prio", 8'h4F, 1'b0, 1'b0, 2'd2);

        // Reach FALHA again, then reset mid-fault
        nivel = 2'b00;
        tick(5);
        outs("drain2", 8'h3F, 1'b0, 1'b0, 2'd2);
        tick(1);
        outs("parado2", 8'h3F, 1'b0, 1'b0, 2'd0);
        tick(1);
        outs("refill2", 8'hBF, 1'b1, 1'b0, 2'd1);
        tick(16);
        outs("fault2", 8'h71, 1'b0, 1'b1, 2'd3);
        reset = 1'b1;
        nivel = 2'b11;
        tick(1);
        outs("rst_mid", 8'h3F, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        nivel = 2'b00;
        tick(1);
        outs("rst_refill", 8'hBF, 1'b1, 1'b0, 2'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
